load_unit: RTL and testbench

- Multicycle load-execution stage directly downstream of the load decoder.
- Accepts a decoded load (LOADop, unaligned flag, byte address) and runs the memory read handshake. Then aligns and sign/zero-extends the returned word and hands the result to register writeback.
- Raises misaligned and access-fault indications to the trap logic instead of producing a result.
- Also serves AMO data loads; these arrive already decoded as LW.

---
 rtl/load_unit_pkg.sv | 21 ++
 rtl/load_align_extend.sv | 30 +++
 rtl/load_unit.sv | 157 +++++++++++++++
 tb/tb_load_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared load-unit definitions: load-op encodings (funct3 style) and the FSM
// state type used by the load execution stage.
package load_unit_pkg;

  localparam int LOAD_OP_WIDTH = 3;

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'b000;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'b001;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'b010;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'b100;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    RESP   = 3'd2,
    FAULT  = 3'd3,
    AFAULT = 3'd4
  } load_unit_state_t;

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed byte/half of a returned memory word and sign- or
// zero-extends it to XLEN according to the load type.
module load_align_extend
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [LOAD_OP_WIDTH-1:0] load_op_i,
  input  logic [1:0]               byte_off_i,
  input  logic [XLEN-1:0]          word_i,
  output logic [XLEN-1:0]          result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
    half_sel = word_i[{byte_off_i[1], 4'b0000} +: 16];
    case (load_op_i)
      LOAD_OP_LBU: result_o = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_OP_LH:  result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LOAD_OP_LHU: result_o = {{(XLEN-16){1'b0}}, half_sel};
      LOAD_OP_LW:  result_o = word_i;
      // LB and every unlisted encoding
      default:     result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multicycle load execution stage: runs the memory read handshake, aligns and
// extends the data, and reports misaligned / access faults to the trap logic.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LOAD_OP_WIDTH-1:0] LOADop,
  input  logic                     is_load_unaligned,
  input  logic [XLEN-1:0]          addr,
  input  logic                     flush,
  output logic                     busy,
  output logic                     mem_valid,
  output logic [XLEN-1:0]          mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_err,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     result_valid,
  output logic [XLEN-1:0]          result,
  output logic                     fault_misaligned,
  output logic                     fault_access,
  output logic [XLEN-1:0]          fault_addr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  load_unit_state_t         state_q, state_d;
  logic [LOAD_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [XLEN-1:0]          rdata_q, rdata_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic [XLEN-1:0]          fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     drop_q, drop_d;

  logic [XLEN-1:0] aligned;
  logic            drop_eff;
  logic            timeout_hit;

  load_align_extend #(.XLEN(XLEN)) u_align (
    .load_op_i  (op_q),
    .byte_off_i (addr_q[1:0]),
    .word_i     (rdata_q),
    .result_o   (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      result_q     <= '0;
      fault_addr_q <= '0;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      result_q     <= result_d;
      fault_addr_q <= fault_addr_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
    end
  end

  // A flush seen at any point of REQ kills the eventual pulse, but the bus
  // transaction itself is always allowed to finish.
  assign drop_eff    = drop_q | flush;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    addr_d           = addr_q;
    rdata_d          = rdata_q;
    result_d         = result_q;
    fault_addr_d     = fault_addr_q;
    cnt_d            = cnt_q;
    drop_d           = drop_q;
    mem_valid        = 1'b0;
    result_valid     = 1'b0;
    fault_misaligned = 1'b0;
    fault_access     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = LOADop;
          addr_d = addr;
          cnt_d  = '0;
          drop_d = 1'b0;
          if (is_load_unaligned) begin
            fault_addr_d = addr;
            state_d      = FAULT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        drop_d    = drop_eff;
        if (mem_ready) begin
          if (drop_eff) begin
            state_d = IDLE;
          end else if (mem_err) begin
            fault_addr_d = addr_q;
            state_d      = AFAULT;
          end else begin
            rdata_d = mem_rdata;
            state_d = RESP;
          end
        end else if (timeout_hit) begin
          if (drop_eff) begin
            state_d = IDLE;
          end else begin
            fault_addr_d = addr_q;
            state_d      = AFAULT;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (!flush) begin
          result_valid = 1'b1;
          result_d     = aligned;
        end
        state_d = IDLE;
      end
      FAULT: begin
        fault_misaligned = !flush;
        state_d          = IDLE;
      end
      AFAULT: begin
        fault_access = !flush;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign result     = result_valid ? aligned : result_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit: stimulus pushes expected pulses,
// a negedge monitor pops and compares them against the DUT.
module tb_load_unit;
  import load_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  LOADop = '0;
  logic        is_load_unaligned = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        busy, mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        result_valid;
  logic [31:0] result;
  logic        fault_misaligned, fault_access;
  logic [31:0] fault_addr;

  typedef struct {
    logic [2:0]  pulses;   // {result_valid, fault_misaligned, fault_access}
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  load_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .LOADop(LOADop),
    .is_load_unaligned(is_load_unaligned), .addr(addr), .flush(flush),
    .busy(busy), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .result_valid(result_valid), .result(result),
    .fault_misaligned(fault_misaligned), .fault_access(fault_access),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: pick the addressed byte/half by shifting, extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (op)
      LOAD_OP_LBU: return b;
      LOAD_OP_LH:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      LOAD_OP_LHU: return h;
      LOAD_OP_LW:  return w;
      default:     return (b >= 32'h80) ? b - 32'h100 : b;
    endcase
  endfunction

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [2:0] pl;
    exp_t e;
    if (!rst) begin
      pl = {result_valid, fault_misaligned, fault_access};
      if (pl != 3'b000) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_pulse: got %b, expected none (cycle %0d)", pl, cyc);
        end else begin
          e = sbq.pop_front();
          chk("pulse_kind", {29'd0, pl}, {29'd0, e.pulses});
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_data", e.pulses[2] ? result : fault_addr, e.val);
        end
      end
    end
  end

  // fl: cycle offset after start at which flush is raised (0 = none).
  // dup: issue a conflicting start in the first busy cycle.
  task automatic txn(input logic [2:0] op, input logic un, input logic [31:0] a,
                     input logic [31:0] rd, input int w, input logic err,
                     input int fl, input logic dup);
    exp_t e;
    int sc, req_end;
    logic drop_req, flushed;
    logic [31:0] wa;
    wa       = {a[31:2], 2'b00};
    req_end  = un ? 0 : ((w >= TO) ? TO : w + 1);
    drop_req = (fl >= 1) && (fl <= req_end);
    flushed  = (fl >= 1) && (fl <= req_end + 1);
    @(posedge clk); #1;
    start = 1'b1; LOADop = op; is_load_unaligned = un; addr = a; sc = cyc;
    $display("txn op=%0d un=%0d addr=%h rdata=%h wait=%0d err=%0d flush@%0d dup=%0d",
             op, un, a, rd, w, err, fl, dup);
    if (!flushed) begin
      if (un)               e = '{3'b010, a, sc + 1};
      else if (w >= TO)     e = '{3'b001, a, sc + TO + 1};
      else if (err)         e = '{3'b001, a, sc + w + 2};
      else                  e = '{3'b100, ref_load(op, a, rd), sc + w + 2};
      sbq.push_back(e);
    end
    for (int n = 1; n <= req_end + 2; n++) begin
      @(posedge clk); #1;
      start = dup && (n == 1);
      if (dup && n == 1) begin
        LOADop = LOAD_OP_LW; is_load_unaligned = 1'b1; addr = 32'hDEAD_BEE1;
      end
      flush     = (n == fl);
      mem_ready = !un && (w < TO) && (n == w + 1);
      mem_err   = err;
      mem_rdata = mem_ready ? rd : $urandom;
      @(negedge clk);
      if (n <= req_end) begin
        chk("mem_valid_req", {31'd0, mem_valid}, 32'd1);
        chk("mem_addr", mem_addr, wa);
      end else begin
        chk("mem_valid_idle", {31'd0, mem_valid}, 32'd0);
      end
      chk("busy", {31'd0, busy},
          {31'd0, (n <= req_end) || (n == req_end + 1 && !drop_req)});
    end
    start = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    sbq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, fl, req_end;
    logic un, err, dup;
    logic [2:0] op;
    logic [31:0] a;

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_pulses", {29'd0, result_valid, fault_misaligned, fault_access}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    txn(LOAD_OP_LB,  0, 32'h1003, 32'h80FF1234, 0, 0, 0, 0);
    txn(LOAD_OP_LBU, 0, 32'h1003, 32'h80FF1234, 0, 0, 0, 0);
    txn(LOAD_OP_LH,  0, 32'h1002, 32'h80FF1234, 0, 0, 0, 0);
    txn(LOAD_OP_LHU, 0, 32'h1000, 32'h80FF1234, 0, 0, 0, 0);
    txn(LOAD_OP_LW,  0, 32'h1000, 32'h80FF1234, 3, 0, 0, 0);
    txn(LOAD_OP_LW,  1, 32'h2001, 32'h0,        0, 0, 0, 0);
    txn(LOAD_OP_LW,  0, 32'h3004, 32'h12345678, 1, 1, 0, 0);
    txn(LOAD_OP_LW,  0, 32'h3008, 32'h0,        9, 0, 0, 0);
    txn(LOAD_OP_LW,  0, 32'h400C, 32'hCAFEF00D, 2, 0, 1, 0);
    txn(LOAD_OP_LW,  0, 32'h4000, 32'hCAFEF00D, 2, 0, 0, 1);
    txn(LOAD_OP_LB,  0, 32'h4001, 32'hCAFEF00D, 0, 0, 2, 0);
    txn(3'b111,      0, 32'h1001, 32'h00008000, 0, 0, 0, 0);

    // start together with flush in IDLE is ignored
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; LOADop = LOAD_OP_LW; is_load_unaligned = 1'b0; addr = 32'h5000;
    $display("txn start+flush in IDLE addr=%h", addr);
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    chk("flush_start_mem_valid", {31'd0, mem_valid}, 32'd0);

    // asynchronous reset in the middle of REQ
    @(posedge clk); #1;
    start = 1'b1; LOADop = LOAD_OP_LW; is_load_unaligned = 1'b0; addr = 32'h6000;
    $display("txn async reset mid-REQ addr=%h", addr);
    @(posedge clk); #1; start = 1'b0;
    #1; chk("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_fault_addr", fault_addr, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    txn(LOAD_OP_LHU, 0, 32'h7002, 32'hBEEF1234, 1, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      un  = ($urandom_range(0, 5) == 0);
      a   = $urandom;
      w   = $urandom_range(0, 5);
      err = ($urandom_range(0, 7) == 0);
      dup = ($urandom_range(0, 5) == 0);
      req_end = un ? 0 : ((w >= TO) ? TO : w + 1);
      fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, req_end + 1) : 0;
      txn(op, un, a, $urandom, w, err, fl, dup);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
